tl_rr_grant_arbiter: RTL and testbench

- N-way round-robin arbiter with valid/ready handshake; selects one requester per beat and drives a one-hot grant vector plus a registered burst lock.
- Sits directly upstream of the grant one-hot protocol monitor. Its out_grant and out_valid feed that monitor, which fatals if two or more grant bits are high together.
- Multi-beat bursts (in_last low) hold the grant on one requester until the last beat completes.

---
 rtl/tl_rr_grant_arbiter.sv | 129 ++++++++++++
 tb/tb_tl_rr_grant_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tl_rr_grant_arbiter.sv
// tl_rr_grant_arbiter: N-way round-robin arbiter with valid/ready handshake.
// Drives a one-hot grant (all-zero when idle or in reset) and a binary index.
// Optional burst locking is compiled in with `define TL_RR_ARB_BURST_LOCK_EN;
// without it, in_last is ignored and every accepted beat re-arbitrates.
module tl_rr_grant_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned IDXW = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_grant,
  output logic [IDXW-1:0] out_idx,
  output logic            out_locked
);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_d;
  logic [IDXW-1:0] cand;
  logic [IDXW-1:0] scan_idx;
  logic            scan_hit;
  logic [IDXW-1:0] g;
  logic            sel_valid;
  logic [IDXW-1:0] ptr_inc;
  logic            fire;

`ifdef TL_RR_ARB_BURST_LOCK_EN
  logic            lock_q;
  logic            lock_d;
  logic [IDXW-1:0] owner_q;
  logic [IDXW-1:0] owner_d;
`else
  logic            unused_last;
  assign unused_last = ^in_last;
`endif

  // Round-robin scan: first valid requester starting at ptr, wrapping mod N.
  always_comb begin
    scan_idx = '0;
    scan_hit = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDXW'((32'(ptr) + k) % N);
      if (!scan_hit && in_valid[cand]) begin
        scan_hit = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // Grant selection: a held lock pins the grant to its owner, bubbles included.
  always_comb begin
    g         = scan_idx;
    sel_valid = scan_hit;
`ifdef TL_RR_ARB_BURST_LOCK_EN
    if (lock_q) begin
      g         = owner_q;
      sel_valid = in_valid[owner_q];
    end
`endif
  end

  // Downstream-facing outputs, forced to an all-zero grant while in reset.
  always_comb begin
    out_valid = 1'b0;
    out_grant = '0;
    out_idx   = '0;
    in_ready  = '0;
    if (reset_n && sel_valid) begin
      out_valid = 1'b1;
      out_grant = N'(1) << g;
      out_idx   = g;
      in_ready  = {N{out_ready}} & out_grant;
    end
  end

  assign fire    = out_valid & out_ready;
  assign ptr_inc = (32'(g) == N - 32'd1) ? '0 : g + IDXW'(1);

  // Next-state: advance ptr past the winner when a burst (or single beat) ends.
  always_comb begin
    ptr_d = ptr;
`ifdef TL_RR_ARB_BURST_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
    if (fire) begin
      if (in_last[g]) begin
        lock_d = 1'b0;
        ptr_d  = ptr_inc;
      end else begin
        lock_d  = 1'b1;
        owner_d = g;
      end
    end
`else
    if (fire) begin
      ptr_d = ptr_inc;
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr <= '0;
`ifdef TL_RR_ARB_BURST_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
`endif
    end else begin
      ptr <= ptr_d;
`ifdef TL_RR_ARB_BURST_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
`endif
    end
  end

`ifdef TL_RR_ARB_BURST_LOCK_EN
  assign out_locked = lock_q;
`else
  assign out_locked = 1'b0;
`endif

endmodule

// File: tb/tb_tl_rr_grant_arbiter.sv
// Directed bench for tl_rr_grant_arbiter (N=3). Expectations follow
// TL_RR_ARB_BURST_LOCK_EN so the same bench covers both builds.
module tb_tl_rr_grant_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned IDXW = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_grant;
  logic [IDXW-1:0] out_idx;
  logic            out_locked;

  int errors = 0;
  int checks = 0;

  tl_rr_grant_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grant  (out_grant),
    .out_idx    (out_idx),
    .out_locked (out_locked)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [N-1:0] rr_seq [6];

  initial begin
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
    rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

    // Reset with every requester valid.
    reset_n   = 1'b0;
    in_valid  = 3'b111;
    in_last   = 3'b111;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_grant",  32'(out_grant),  32'h0);
    chk("rst_valid",  32'(out_valid),  32'h0);
    chk("rst_ready",  32'(in_ready),   32'h0);
    chk("rst_idx",    32'(out_idx),    32'h0);
    chk("rst_locked", 32'(out_locked), 32'h0);

    // Release reset: first grant goes to requester 0, then strict rotation.
    reset_n = 1'b1;
    #1;
    chk("rel_idx", 32'(out_idx), 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(out_grant), 32'(rr_seq[i]));
      chk($sformatf("rr_idx%0d", i),   32'(out_idx),   32'(i % 3));
      tick();
    end

    // Backpressure: grant held on requester 1 with no accept.
    in_valid  = 3'b110;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_grant%0d", i), 32'(out_grant), 32'h2);
      chk($sformatf("bp_ready%0d", i), 32'(in_ready),  32'h0);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_fire_ready", 32'(in_ready), 32'h2);
    tick();
    // ptr is now 2: all valid, no accept -> requester 2.
    in_valid  = 3'b111;
    out_ready = 1'b0;
    #1;
    chk("bp_ptr2", 32'(out_grant), 32'h4);
    // Fire requester 2 to wrap ptr to 0.
    out_ready = 1'b1;
    tick();

    // Three-beat burst from requester 0, others valid throughout.
    in_last = 3'b110;
    #1;
    chk("b1_grant",  32'(out_grant),  32'h1);
    chk("b1_locked", 32'(out_locked), 32'h0);
    tick();
`ifdef TL_RR_ARB_BURST_LOCK_EN
    #1;
    chk("b2_grant",  32'(out_grant),  32'h1);
    chk("b2_locked", 32'(out_locked), 32'h1);
    tick();
    in_last = 3'b111;
    #1;
    chk("b3_grant",  32'(out_grant),  32'h1);
    chk("b3_locked", 32'(out_locked), 32'h1);
    tick();
    #1;
    chk("b_next_grant",  32'(out_grant),  32'h2);
    chk("b_next_locked", 32'(out_locked), 32'h0);
    tick();
    // ptr=2: start a burst on requester 2, then it bubbles.
    in_last = 3'b011;
    #1;
    chk("own_grant", 32'(out_grant), 32'h4);
    tick();
    in_valid = 3'b011;
    #1;
    chk("bub_valid",  32'(out_valid),  32'h0);
    chk("bub_grant",  32'(out_grant),  32'h0);
    chk("bub_locked", 32'(out_locked), 32'h1);
    tick();
    chk("bub2_grant",  32'(out_grant),  32'h0);
    chk("bub2_locked", 32'(out_locked), 32'h1);
`else
    #1;
    chk("b2_grant",  32'(out_grant),  32'h2);
    chk("b2_locked", 32'(out_locked), 32'h0);
    tick();
    in_last = 3'b111;
    #1;
    chk("b3_grant",  32'(out_grant),  32'h4);
    chk("b3_locked", 32'(out_locked), 32'h0);
    tick();
    #1;
    chk("b_next_grant", 32'(out_grant), 32'h1);
    tick();
    // ptr=1: in_last low is ignored, rotation continues.
    in_last = 3'b011;
    #1;
    chk("nl_grant", 32'(out_grant), 32'h2);
    tick();
    in_valid = 3'b011;
    #1;
    chk("nl_next_grant",  32'(out_grant),  32'h1);
    chk("nl_next_locked", 32'(out_locked), 32'h0);
`endif

    // One-cycle reset pulse: lock dropped, ptr back to 0.
    in_valid  = 3'b110;
    in_last   = 3'b111;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("mrst_grant", 32'(out_grant), 32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_grant",  32'(out_grant),  32'h2);
    chk("post_locked", 32'(out_locked), 32'h0);
    in_valid = 3'b111;
    #1;
    chk("post_ptr0", 32'(out_grant), 32'h1);
    chk("post_idx",  32'(out_idx),   32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
